sprite_motion_sched: RTL and testbench

SPRITE_MOTION_SCHED -- requirements
Module: sprite_motion_sched

---
 rtl/sprite_motion_sched_if.sv | 42 ++++
 rtl/sprite_motion_sched.sv | 189 ++++++++++++++++++
 tb/tb_sprite_motion_sched.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/sprite_motion_sched_if.sv
// Bus bundle for sprite_motion_sched: frame sync in, committed sprite
// positions and status out. The optional freeze input exists only when
// MOTION_FREEZE_EN is defined.
interface sprite_motion_sched_if #(
    parameter int NSPR = 4
);
    logic                   vsync;
`ifdef MOTION_FREEZE_EN
    logic                   freeze;
`endif
    logic [11*NSPR-1:0]     posx_all;
    logic [11*NSPR-1:0]     posy_all;
    logic                   busy;
    logic [7:0]             frame_cnt;
    logic                   overrun;

    // Scheduler side: consumes sync, produces positions and status.
    modport slave (
        input  vsync,
`ifdef MOTION_FREEZE_EN
        input  freeze,
`endif
        output posx_all,
        output posy_all,
        output busy,
        output frame_cnt,
        output overrun
    );

    // Sync generator / display side.
    modport master (
        output vsync,
`ifdef MOTION_FREEZE_EN
        output freeze,
`endif
        input  posx_all,
        input  posy_all,
        input  busy,
        input  frame_cnt,
        input  overrun
    );
endinterface

// File: rtl/sprite_motion_sched.sv
// sprite_motion_sched: on each vsync assertion edge, walks every sprite
// through one bounce step (X then Y, one shared adder/comparator), then
// commits all working positions to the outputs in a single edge.
// Optional feature macro: MOTION_FREEZE_EN (adds a freeze input that
// skips frames while high).
module sprite_motion_sched #(
    parameter int NSPR    = 4,
    parameter int HACTIVE = 640,
    parameter int VACTIVE = 480,
    parameter int SPR_W   = 16,
    parameter int SPR_H   = 16,
    parameter int STEP    = 1,
    parameter int VS_POL  = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sprite_motion_sched_if.slave  bus
);
    localparam int          IW      = (NSPR > 1) ? $clog2(NSPR) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NSPR - 1);
    localparam logic [11:0] STEP12  = 12'(STEP);
    localparam logic [11:0] LIM_X   = 12'(HACTIVE - SPR_W);
    localparam logic [11:0] LIM_Y   = 12'(VACTIVE - SPR_H);
    localparam logic        VS_ACT  = 1'(VS_POL);

    typedef enum logic [1:0] {IDLE, UPDX, UPDY, COMMIT} state_t;

    state_t             state_q, state_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic               vs_q;
    logic [10:0]        wx_q [NSPR];
    logic [10:0]        wx_d [NSPR];
    logic [10:0]        wy_q [NSPR];
    logic [10:0]        wy_d [NSPR];
    logic [NSPR-1:0]    dirx_q, dirx_d;   // 1'b0 = moving +, 1'b1 = moving -
    logic [NSPR-1:0]    diry_q, diry_d;
    logic [11*NSPR-1:0] posx_q, posx_d;
    logic [11*NSPR-1:0] posy_q, posy_d;
    logic [7:0]         frame_q, frame_d;
    logic               overrun_q, overrun_d;
    logic               busy_q, busy_d;

    logic               edge_s;
    logic [11:0]        alu_p_s;
    logic               alu_dir_s;
    logic [11:0]        alu_lim_s;
    logic [11:0]        alu_sum_s;
    logic [11:0]        alu_np_s;
    logic               alu_nd_s;
    logic               freeze_s;

    assign edge_s = (vs_q != VS_ACT) && (bus.vsync == VS_ACT);

`ifdef MOTION_FREEZE_EN
    assign freeze_s = bus.freeze;
`else
    assign freeze_s = 1'b0;
`endif

    // Shared bounce step: operand and limit are picked by the current axis.
    always_comb begin
        alu_p_s   = 12'd0;
        alu_dir_s = 1'b0;
        alu_lim_s = LIM_X;
        alu_np_s  = 12'd0;
        alu_nd_s  = 1'b0;
        if (state_q == UPDY) begin
            alu_p_s   = {1'b0, wy_q[idx_q]};
            alu_dir_s = diry_q[idx_q];
            alu_lim_s = LIM_Y;
        end else begin
            alu_p_s   = {1'b0, wx_q[idx_q]};
            alu_dir_s = dirx_q[idx_q];
            alu_lim_s = LIM_X;
        end
        alu_sum_s = alu_p_s + STEP12;
        if (!alu_dir_s) begin
            if (alu_sum_s >= alu_lim_s) begin
                alu_np_s = alu_lim_s;
                alu_nd_s = 1'b1;
            end else begin
                alu_np_s = alu_sum_s;
                alu_nd_s = 1'b0;
            end
        end else begin
            if (alu_p_s <= STEP12) begin
                alu_np_s = 12'd0;
                alu_nd_s = 1'b0;
            end else begin
                alu_np_s = alu_p_s - STEP12;
                alu_nd_s = 1'b1;
            end
        end
    end

    // Next-state logic: sequencer, working-copy updates and commit.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        wx_d      = wx_q;
        wy_d      = wy_q;
        dirx_d    = dirx_q;
        diry_d    = diry_q;
        posx_d    = posx_q;
        posy_d    = posy_q;
        frame_d   = frame_q;
        // An edge landing in any non-idle state (COMMIT included) is dropped.
        overrun_d = overrun_q | (edge_s && (state_q != IDLE));
        case (state_q)
            IDLE: begin
                if (edge_s && !freeze_s) begin
                    state_d = UPDX;
                    idx_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            UPDX: begin
                wx_d[idx_q]   = alu_np_s[10:0];
                dirx_d[idx_q] = alu_nd_s;
                state_d       = UPDY;
            end
            UPDY: begin
                wy_d[idx_q]   = alu_np_s[10:0];
                diry_d[idx_q] = alu_nd_s;
                if (idx_q == LAST_IDX) begin
                    state_d = COMMIT;
                end else begin
                    idx_d   = idx_q + IW'(1);
                    state_d = UPDX;
                end
            end
            COMMIT: begin
                for (int i = 0; i < NSPR; i++) begin
                    posx_d[11*i +: 11] = wx_q[i];
                    posy_d[11*i +: 11] = wy_q[i];
                end
                frame_d = frame_q + 8'd1;
                idx_d   = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State registers with asynchronous reset to the start-of-day layout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            vs_q      <= ~VS_ACT;
            frame_q   <= 8'd0;
            overrun_q <= 1'b0;
            busy_q    <= 1'b0;
            dirx_q    <= '0;
            diry_q    <= '0;
            for (int i = 0; i < NSPR; i++) begin
                wx_q[i]            <= 11'(2 * SPR_W * i);
                wy_q[i]            <= 11'(SPR_H * i);
                posx_q[11*i +: 11] <= 11'(2 * SPR_W * i);
                posy_q[11*i +: 11] <= 11'(SPR_H * i);
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            vs_q      <= bus.vsync;
            frame_q   <= frame_d;
            overrun_q <= overrun_d;
            busy_q    <= busy_d;
            dirx_q    <= dirx_d;
            diry_q    <= diry_d;
            wx_q      <= wx_d;
            wy_q      <= wy_d;
            posx_q    <= posx_d;
            posy_q    <= posy_d;
        end
    end

    assign bus.posx_all  = posx_q;
    assign bus.posy_all  = posy_q;
    assign bus.busy      = busy_q;
    assign bus.frame_cnt = frame_q;
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_sprite_motion_sched.sv
// Testbench for sprite_motion_sched: random frame gaps and random
// mid-pass vsync edges, checked against a bouncing-sprite reference model.
module tb_sprite_motion_sched;
    localparam int NSPR    = 4;
    localparam int HACTIVE = 640;
    localparam int VACTIVE = 480;
    localparam int SPR_W   = 16;
    localparam int SPR_H   = 16;
    localparam int STEP    = 1;
    localparam int VS_POL  = 0;
    localparam logic VS_ACT = 1'(VS_POL);
    localparam int PASS_LEN = 2 * NSPR + 1;

    logic clk;
    logic rst_n;

    sprite_motion_sched_if #(.NSPR(NSPR)) sif();

    sprite_motion_sched #(
        .NSPR(NSPR), .HACTIVE(HACTIVE), .VACTIVE(VACTIVE),
        .SPR_W(SPR_W), .SPR_H(SPR_H), .STEP(STEP), .VS_POL(VS_POL)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;

    // Reference model: position and direction (+1 / -1) per sprite.
    int mx [NSPR];
    int my [NSPR];
    int mdx [NSPR];
    int mdy [NSPR];
    int mframe;
    int movr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NSPR; i++) begin
            mx[i]  = 2 * SPR_W * i;
            my[i]  = SPR_H * i;
            mdx[i] = 1;
            mdy[i] = 1;
        end
        mframe = 0;
        movr   = 0;
    endfunction

    // One axis of a sprite bouncing between 0 and lim.
    function automatic void bounce(inout int p, inout int d, input int lim);
        int np;
        np = p + d * STEP;
        if (np >= lim) begin
            p = lim;
            d = -1;
        end else if (np <= 0) begin
            p = 0;
            d = 1;
        end else begin
            p = np;
        end
    endfunction

    function automatic void model_frame();
        for (int i = 0; i < NSPR; i++) begin
            bounce(mx[i], mdx[i], HACTIVE - SPR_W);
            bounce(my[i], mdy[i], VACTIVE - SPR_H);
        end
        mframe = (mframe + 1) % 256;
    endfunction

    function automatic int out_x(input int i);
        return int'(sif.posx_all[11*i +: 11]);
    endfunction

    function automatic int out_y(input int i);
        return int'(sif.posy_all[11*i +: 11]);
    endfunction

    task automatic check_outputs(input string tag);
        for (int i = 0; i < NSPR; i++) begin
            chk($sformatf("%s_x%0d", tag, i), 32'(out_x(i)), 32'(mx[i]));
            chk($sformatf("%s_y%0d", tag, i), 32'(out_y(i)), 32'(my[i]));
        end
        chk({tag, "_frame"}, 32'(sif.frame_cnt), 32'(mframe));
        chk({tag, "_ovr"}, 32'(sif.overrun), 32'(movr));
    endtask

    // One vsync pulse; if ovr_k > 0, a second edge is launched ovr_k cycles into the pass.
    task automatic do_frame(input int ovr_k);
        int n;
        @(negedge clk) sif.vsync = VS_ACT;
        @(negedge clk) sif.vsync = ~VS_ACT;
        n = 0;
        while (sif.busy && n < 40) begin
            n++;
            if (ovr_k > 0 && n == ovr_k) sif.vsync = VS_ACT;
            else sif.vsync = ~VS_ACT;
            @(negedge clk);
        end
        sif.vsync = ~VS_ACT;
        chk("busy_len", 32'(n), 32'(PASS_LEN));
        model_frame();
        if (ovr_k > 0) movr = 1;
        check_outputs("frame");
        // Gap: the pass must have ended and no second pass may start.
        repeat (1 + $urandom_range(0, 3)) begin
            @(negedge clk);
            chk("idle_busy", 32'(sif.busy), 32'd0);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        sif.vsync = ~VS_ACT;
`ifdef MOTION_FREEZE_EN
        sif.freeze = 1'b0;
`endif
        model_reset();
        repeat (3) @(negedge clk);
        check_outputs("rst");
        chk("rst_busy", 32'(sif.busy), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_outputs("rel");

        // First frame from reset layout.
        do_frame(0);
        chk("f1_s0x", 32'(out_x(0)), 32'd1);
        chk("f1_s0y", 32'(out_y(0)), 32'd1);
        chk("f1_s1x", 32'(out_x(1)), 32'd33);
        chk("f1_s1y", 32'(out_y(1)), 32'd17);
        chk("f1_cnt", 32'(sif.frame_cnt), 32'd1);

        for (int f = 2; f <= 4; f++) do_frame(0);
        chk("pre_ovr", 32'(sif.overrun), 32'd0);
        // Second edge three cycles into the pass.
        do_frame(3);
        chk("ovr_set", 32'(sif.overrun), 32'd1);
        chk("ovr_cnt", 32'(sif.frame_cnt), 32'd5);

        for (int f = 6; f <= 930; f++) begin
            int k;
            k = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 9)) : 0;
            do_frame(k);
            if (f == 623) chk("x_623", 32'(out_x(0)), 32'd623);
            if (f == 624) chk("x_lim", 32'(out_x(0)), 32'd624);
            if (f == 625) chk("x_back", 32'(out_x(0)), 32'd623);
            if (f == 927) chk("y_one", 32'(out_y(0)), 32'd1);
            if (f == 928) chk("y_zero", 32'(out_y(0)), 32'd0);
            if (f == 929) chk("y_up", 32'(out_y(0)), 32'd1);
        end

        // Reset asserted during UPDY of sprite 2.
        begin
            int n;
            @(negedge clk) sif.vsync = VS_ACT;
            @(negedge clk) sif.vsync = ~VS_ACT;
            n = 1;
            while (n < 6) begin
                @(negedge clk);
                n++;
            end
            chk("mid_busy", 32'(sif.busy), 32'd1);
            rst_n = 1'b0;
            #1;
            model_reset();
            check_outputs("midrst");
            chk("midrst_busy", 32'(sif.busy), 32'd0);
            @(negedge clk);
            rst_n = 1'b1;
            repeat (20) @(negedge clk);
            check_outputs("postrst");
            chk("postrst_busy", 32'(sif.busy), 32'd0);
        end

`ifdef MOTION_FREEZE_EN
        // Frozen frames: no pass, nothing moves.
        sif.freeze = 1'b1;
        for (int p = 0; p < 3; p++) begin
            int seen;
            seen = 0;
            @(negedge clk) sif.vsync = VS_ACT;
            @(negedge clk) sif.vsync = ~VS_ACT;
            repeat (12) begin
                if (sif.busy) seen = 1;
                @(negedge clk);
            end
            chk("frz_busy", 32'(seen), 32'd0);
            check_outputs("frz");
        end
        sif.freeze = 1'b0;
        do_frame(0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
